// File: rtl/lpif_pkg.sv
// Shared encodings for the PHY-side LPIF state controller.
// Optional stall timeout is enabled by defining LPIF_STALL_TIMEOUT_EN.
package lpif_pkg;

  localparam logic [3:0] LS_NOP     = 4'h0;
  localparam logic [3:0] LS_ACTIVE  = 4'h1;
  localparam logic [3:0] LS_L1      = 4'h4;
  localparam logic [3:0] LS_RETRAIN = 4'hB;
  localparam logic [3:0] LS_RESET   = 4'hF;

  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    S_RESET,
    S_ACTIVE,
    S_STALL,
    S_L1,
    S_L1_EXIT,
    S_RETRAIN
  } st_e;

endpackage

// File: rtl/lpif_stall_timer.sv
// Clearable saturating cycle counter; expired flags the LIMIT-th enabled cycle.
// Only consequential when LPIF_STALL_TIMEOUT_EN is defined.
module lpif_stall_timer
  import lpif_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q >= LAST);

endmodule

// File: rtl/lpif_state_ctrl.sv
// PHY-side LPIF state controller: L1/retrain/link-down arbitration and stall.
// Define LPIF_STALL_TIMEOUT_EN to bound the stall handshake by STALL_TIMEOUT.
module lpif_state_ctrl
  import lpif_pkg::*;
#(
  parameter int         STALL_TIMEOUT = 1023,
  parameter logic [2:0] PROTOCOL      = 3'b000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] state_req,
  input  logic       stall_ack,
  input  logic       ltssm_up,
  input  logic       ltssm_recovery,
  input  logic       ltssm_l1,
  input  logic [2:0] ltssm_width,
  output logic [3:0] state_sts,
  output logic       link_up,
  output logic       stall_req,
  output logic       phyinl1,
  output logic       phyinrecenter,
  output logic [2:0] link_cfg,
  output logic       protocol_valid,
  output logic [2:0] protocol,
  output logic       trdy_en,
  output logic       ltssm_l1_req,
  output logic       ltssm_retrain_req,
  output logic       stall_timeout_err
);

`ifdef LPIF_STALL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  st_e        st_q, st_d, tgt_q, tgt_d;
  logic       llrt_q, llrt_d;
  logic [3:0] sts_q, sts_d;
  logic [2:0] cfg_q, cfg_d;
  logic       up_q, up_d, sreq_q, sreq_d;
  logic       inl1_q, inl1_d, recen_q, recen_d;
  logic       pv_q, pv_d, trdy_q, trdy_d;
  logic       l1req_q, l1req_d, rtreq_q, rtreq_d;
  logic       err_q, err_d;
  logic       tmr_en, tmr_exp, tmo;

  assign tmr_en = (st_q == S_STALL) && sreq_q;
  assign tmo    = tmr_exp & TMO_EN;

  lpif_stall_timer #(.LIMIT(STALL_TIMEOUT)) u_timer (
    .clk     (Clk),
    .rst     (reset),
    .clr     (!tmr_en),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    st_d    = st_q;
    tgt_d   = tgt_q;
    llrt_d  = llrt_q;
    sts_d   = sts_q;
    cfg_d   = cfg_q;
    up_d    = up_q;
    sreq_d  = sreq_q;
    inl1_d  = inl1_q;
    recen_d = recen_q;
    pv_d    = pv_q;
    trdy_d  = trdy_q;
    l1req_d = l1req_q;
    rtreq_d = 1'b0;
    err_d   = err_q;
    // Link loss outside the L1 family drops straight back to reset state.
    if (!ltssm_up && (st_q inside {S_ACTIVE, S_STALL, S_RETRAIN})) begin
      st_d    = S_RESET;
      llrt_d  = 1'b0;
      sts_d   = LS_RESET;
      cfg_d   = '0;
      up_d    = 1'b0;
      sreq_d  = 1'b0;
      inl1_d  = 1'b0;
      recen_d = 1'b0;
      pv_d    = 1'b0;
      trdy_d  = 1'b0;
      l1req_d = 1'b0;
    end else begin
      unique case (st_q)
        S_RESET: begin
          if (ltssm_up && state_req == LS_ACTIVE) begin
            st_d   = S_ACTIVE;
            sts_d  = LS_ACTIVE;
            cfg_d  = ltssm_width;
            up_d   = 1'b1;
            pv_d   = 1'b1;
            trdy_d = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (ltssm_recovery || state_req == LS_L1 ||
              state_req == LS_RETRAIN) begin
            st_d   = S_STALL;
            trdy_d = 1'b0;
            sreq_d = !stall_ack;
            tgt_d  = (!ltssm_recovery && state_req == LS_L1) ?
                     S_L1 : S_RETRAIN;
            llrt_d = !ltssm_recovery && state_req == LS_RETRAIN;
          end
        end
        S_STALL: begin
          if (!sreq_q) begin
            if (!stall_ack) sreq_d = 1'b1;
          end else if (stall_ack || tmo) begin
            sreq_d = 1'b0;
            st_d   = tgt_q;
            err_d  = err_q | !stall_ack;
            if (tgt_q == S_L1) begin
              l1req_d = 1'b1;
            end else begin
              sts_d   = LS_RETRAIN;
              recen_d = 1'b1;
              rtreq_d = llrt_q;
            end
          end
        end
        S_L1: begin
          if (ltssm_l1) begin
            sts_d  = LS_L1;
            inl1_d = 1'b1;
          end
          if (state_req == LS_ACTIVE) begin
            l1req_d = 1'b0;
            st_d    = S_L1_EXIT;
          end
        end
        S_L1_EXIT: begin
          if (ltssm_up && !ltssm_l1) begin
            st_d   = S_ACTIVE;
            sts_d  = LS_ACTIVE;
            inl1_d = 1'b0;
            trdy_d = 1'b1;
          end
        end
        S_RETRAIN: begin
          if (ltssm_up && !ltssm_recovery) begin
            st_d    = S_ACTIVE;
            sts_d   = LS_ACTIVE;
            recen_d = 1'b0;
            trdy_d  = 1'b1;
          end
        end
        default: st_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      st_q    <= S_RESET;
      tgt_q   <= S_RETRAIN;
      llrt_q  <= 1'b0;
      sts_q   <= LS_RESET;
      cfg_q   <= '0;
      up_q    <= 1'b0;
      sreq_q  <= 1'b0;
      inl1_q  <= 1'b0;
      recen_q <= 1'b0;
      pv_q    <= 1'b0;
      trdy_q  <= 1'b0;
      l1req_q <= 1'b0;
      rtreq_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      tgt_q   <= tgt_d;
      llrt_q  <= llrt_d;
      sts_q   <= sts_d;
      cfg_q   <= cfg_d;
      up_q    <= up_d;
      sreq_q  <= sreq_d;
      inl1_q  <= inl1_d;
      recen_q <= recen_d;
      pv_q    <= pv_d;
      trdy_q  <= trdy_d;
      l1req_q <= l1req_d;
      rtreq_q <= rtreq_d;
      err_q   <= err_d;
    end
  end

  assign state_sts         = sts_q;
  assign link_up           = up_q;
  assign stall_req         = sreq_q;
  assign phyinl1           = inl1_q;
  assign phyinrecenter     = recen_q;
  assign link_cfg          = cfg_q;
  assign protocol_valid    = pv_q;
  assign protocol          = PROTOCOL;
  assign trdy_en           = trdy_q;
  assign ltssm_l1_req      = l1req_q;
  assign ltssm_retrain_req = rtreq_q;
  assign stall_timeout_err = err_q;

endmodule

// File: tb/tb_lpif_state_ctrl.sv
// Bench for lpif_state_ctrl: directed scenarios plus random run vs a model.
// Expectations adapt when LPIF_STALL_TIMEOUT_EN is defined.
module tb_lpif_state_ctrl;

  localparam int         TMO  = 8;
  localparam logic [2:0] PROT = 3'b000;
`ifdef LPIF_STALL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset;
  logic [3:0] state_req;
  logic       stall_ack, ltssm_up, ltssm_recovery, ltssm_l1;
  logic [2:0] ltssm_width;
  logic [3:0] state_sts;
  logic       link_up, stall_req, phyinl1, phyinrecenter;
  logic [2:0] link_cfg, protocol;
  logic       protocol_valid, trdy_en, ltssm_l1_req;
  logic       ltssm_retrain_req, stall_timeout_err;

  lpif_state_ctrl #(.STALL_TIMEOUT(TMO), .PROTOCOL(PROT)) dut (
    .Clk(Clk), .reset(reset), .state_req(state_req),
    .stall_ack(stall_ack), .ltssm_up(ltssm_up),
    .ltssm_recovery(ltssm_recovery), .ltssm_l1(ltssm_l1),
    .ltssm_width(ltssm_width), .state_sts(state_sts),
    .link_up(link_up), .stall_req(stall_req), .phyinl1(phyinl1),
    .phyinrecenter(phyinrecenter), .link_cfg(link_cfg),
    .protocol_valid(protocol_valid), .protocol(protocol),
    .trdy_en(trdy_en), .ltssm_l1_req(ltssm_l1_req),
    .ltssm_retrain_req(ltssm_retrain_req),
    .stall_timeout_err(stall_timeout_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: link phases named by what the link is doing.
  localparam int M_DOWN = 0, M_UP = 1, M_QUIESCE = 2;
  localparam int M_LOWPWR = 3, M_WAKE = 4, M_RECENTER = 5;
  int         m_mode, m_wait;
  bit         m_goal_l1, m_ll;
  logic [3:0] m_sts;
  logic [2:0] m_cfg;
  bit m_up, m_sreq, m_inl1, m_rec, m_pv, m_trdy, m_l1r, m_rt, m_err;

  task automatic model_clear(input bit full);
    m_mode = M_DOWN; m_wait = 0; m_sts = 4'hF; m_cfg = 3'b000;
    m_up = 0; m_sreq = 0; m_inl1 = 0; m_rec = 0; m_pv = 0;
    m_trdy = 0; m_l1r = 0; m_rt = 0;
    if (full) m_err = 0;
  endtask

  task automatic model_update();
    m_rt = 0;
    if (reset) model_clear(1);
    else if (!ltssm_up && (m_mode == M_UP || m_mode == M_QUIESCE ||
             m_mode == M_RECENTER)) model_clear(0);
    else if (m_mode == M_DOWN) begin
      if (ltssm_up && state_req == 4'h1) begin
        m_mode = M_UP; m_sts = 4'h1; m_cfg = ltssm_width;
        m_up = 1; m_pv = 1; m_trdy = 1;
      end
    end else if (m_mode == M_UP) begin
      if (ltssm_recovery || state_req == 4'h4 || state_req == 4'hB) begin
        m_mode = M_QUIESCE; m_trdy = 0; m_sreq = !stall_ack; m_wait = 0;
        m_goal_l1 = !ltssm_recovery && state_req == 4'h4;
        m_ll = !ltssm_recovery && state_req == 4'hB;
      end
    end else if (m_mode == M_QUIESCE) begin
      if (!m_sreq) begin
        if (!stall_ack) begin m_sreq = 1; m_wait = 0; end
      end else begin
        m_wait++;
        if (stall_ack || (TMO_EN && m_wait >= TMO)) begin
          if (!stall_ack) m_err = 1;
          m_sreq = 0;
          if (m_goal_l1) begin m_mode = M_LOWPWR; m_l1r = 1; end
          else begin
            m_mode = M_RECENTER; m_sts = 4'hB; m_rec = 1; m_rt = m_ll;
          end
        end
      end
    end else if (m_mode == M_LOWPWR) begin
      if (ltssm_l1) begin m_sts = 4'h4; m_inl1 = 1; end
      if (state_req == 4'h1) begin m_l1r = 0; m_mode = M_WAKE; end
    end else if (m_mode == M_WAKE) begin
      if (ltssm_up && !ltssm_l1) begin
        m_mode = M_UP; m_sts = 4'h1; m_inl1 = 0; m_trdy = 1;
      end
    end else begin
      if (ltssm_up && !ltssm_recovery) begin
        m_mode = M_UP; m_sts = 4'h1; m_rec = 0; m_trdy = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  function automatic logic [18:0] dut_vec();
    return {state_sts, link_up, stall_req, phyinl1, phyinrecenter,
            link_cfg, protocol_valid, protocol, trdy_en, ltssm_l1_req,
            ltssm_retrain_req, stall_timeout_err};
  endfunction

  function automatic logic [18:0] model_vec();
    return {m_sts, m_up, m_sreq, m_inl1, m_rec, m_cfg, m_pv, PROT,
            m_trdy, m_l1r, m_rt, m_err};
  endfunction

  task automatic test_reset();
    reset = 1; step(); step(); reset = 0;
    checks++;
    if (state_sts !== 4'hF) begin
      errors++; $display("FAIL reset_sts: got %h want F", state_sts);
    end
    checks++;
    if ({link_up, stall_req, phyinl1, phyinrecenter, protocol_valid,
         trdy_en, ltssm_l1_req, ltssm_retrain_req, stall_timeout_err}
        !== 9'b0) begin
      errors++; $display("FAIL reset_flags: some flag nonzero");
    end
    checks++;
    if (link_cfg !== 3'b000 || protocol !== PROT) begin
      errors++;
      $display("FAIL reset_cfg: cfg %b prot %b want 000/%b",
               link_cfg, protocol, PROT);
    end
  endtask

  task automatic test_bringup();
    ltssm_up = 1; ltssm_width = 3'b100; state_req = 4'h1;
    step(); state_req = 4'h0; ltssm_width = 3'b010;
    checks++;
    if (state_sts !== 4'h1 || link_up !== 1'b1) begin
      errors++; $display("FAIL bringup_sts: sts %h up %b want 1/1",
                         state_sts, link_up);
    end
    checks++;
    if (link_cfg !== 3'b100 || protocol_valid !== 1'b1 ||
        trdy_en !== 1'b1) begin
      errors++; $display("FAIL bringup_cfg: cfg %b pv %b trdy %b",
                         link_cfg, protocol_valid, trdy_en);
    end
    step();
    checks++;
    if (link_cfg !== 3'b100) begin
      errors++; $display("FAIL cfg_latched: got %b want 100", link_cfg);
    end
  endtask

  task automatic test_l1();
    int hi;
    state_req = 4'h4; stall_ack = 0; step(); state_req = 4'h0;
    checks++;
    if (stall_req !== 1'b1 || trdy_en !== 1'b0 || state_sts !== 4'h1) begin
      errors++; $display("FAIL l1_stall_start: sreq %b trdy %b sts %h",
                         stall_req, trdy_en, state_sts);
    end
    hi = 1;
    for (int i = 0; i < 5; i++) begin
      step(); if (stall_req) hi++;
    end
    stall_ack = 1; step(); stall_ack = 0;
    checks++;
    if (hi !== 6 || stall_req !== 1'b0 || ltssm_l1_req !== 1'b1) begin
      errors++; $display("FAIL l1_handshake: hi %0d sreq %b l1req %b want 6/0/1",
                         hi, stall_req, ltssm_l1_req);
    end
    ltssm_l1 = 1; step();
    checks++;
    if (state_sts !== 4'h4 || phyinl1 !== 1'b1) begin
      errors++; $display("FAIL l1_entered: sts %h inl1 %b want 4/1",
                         state_sts, phyinl1);
    end
    state_req = 4'h1; step(); state_req = 4'h0;
    checks++;
    if (ltssm_l1_req !== 1'b0) begin
      errors++; $display("FAIL l1_req_drop: got %b want 0", ltssm_l1_req);
    end
    ltssm_l1 = 0; step();
    checks++;
    if (state_sts !== 4'h1 || phyinl1 !== 1'b0 || trdy_en !== 1'b1) begin
      errors++; $display("FAIL l1_exit: sts %h inl1 %b trdy %b want 1/0/1",
                         state_sts, phyinl1, trdy_en);
    end
  endtask

  task automatic test_recovery_priority();
    ltssm_recovery = 1; state_req = 4'h4; step(); state_req = 4'h0;
    stall_ack = 1; step(); stall_ack = 0;
    checks++;
    if (state_sts !== 4'hB || phyinrecenter !== 1'b1 ||
        ltssm_retrain_req !== 1'b0 || ltssm_l1_req !== 1'b0) begin
      errors++; $display("FAIL recov_prio: sts %h rec %b rt %b l1r %b",
                         state_sts, phyinrecenter, ltssm_retrain_req,
                         ltssm_l1_req);
    end
    ltssm_recovery = 0; step();
    checks++;
    if (state_sts !== 4'h1 || phyinrecenter !== 1'b0) begin
      errors++; $display("FAIL recov_exit: sts %h rec %b want 1/0",
                         state_sts, phyinrecenter);
    end
  endtask

  task automatic test_ll_retrain();
    state_req = 4'hB; step(); state_req = 4'h0;
    stall_ack = 1; step(); stall_ack = 0;
    checks++;
    if (ltssm_retrain_req !== 1'b1 || state_sts !== 4'hB) begin
      errors++; $display("FAIL ll_retrain: rt %b sts %h want 1/B",
                         ltssm_retrain_req, state_sts);
    end
    step();
    checks++;
    if (ltssm_retrain_req !== 1'b0 || state_sts !== 4'h1) begin
      errors++; $display("FAIL retrain_pulse: rt %b sts %h want 0/1",
                         ltssm_retrain_req, state_sts);
    end
  endtask

  task automatic test_timeout();
    int n;
    state_req = 4'h4; stall_ack = 0; step(); state_req = 4'h0;
    n = 1;
    for (int i = 0; i < 20 && stall_req; i++) begin
      step(); if (stall_req) n++;
    end
    checks++;
    if (TMO_EN) begin
      if (n !== TMO || stall_timeout_err !== 1'b1 ||
          ltssm_l1_req !== 1'b1) begin
        errors++; $display("FAIL timeout: hi %0d err %b l1r %b want %0d/1/1",
                           n, stall_timeout_err, ltssm_l1_req, TMO);
      end
    end else begin
      if (n !== 21 || stall_timeout_err !== 1'b0 || stall_req !== 1'b1) begin
        errors++; $display("FAIL no_timeout: hi %0d err %b sreq %b want 21/0/1",
                           n, stall_timeout_err, stall_req);
      end
    end
    if (stall_req) begin stall_ack = 1; step(); stall_ack = 0; end
    state_req = 4'h1; step(); state_req = 4'h0; step();
    checks++;
    if (state_sts !== 4'h1) begin
      errors++; $display("FAIL timeout_recover: sts %h want 1", state_sts);
    end
  endtask

  task automatic test_drop_in_stall();
    state_req = 4'h4; stall_ack = 0; step(); state_req = 4'h0;
    ltssm_up = 0; step();
    checks++;
    if (state_sts !== 4'hF || stall_req !== 1'b0 || link_up !== 1'b0 ||
        link_cfg !== 3'b000 || trdy_en !== 1'b0) begin
      errors++; $display("FAIL drop_stall: sts %h sreq %b up %b cfg %b",
                         state_sts, stall_req, link_up, link_cfg);
    end
    ltssm_up = 1; ltssm_width = 3'b001; state_req = 4'h1; step();
    state_req = 4'h0;
    checks++;
    if (state_sts !== 4'h1 || link_cfg !== 3'b001) begin
      errors++; $display("FAIL rebringup: sts %h cfg %b want 1/001",
                         state_sts, link_cfg);
    end
  endtask

  task automatic test_random();
    logic [3:0] reqs [5];
    reqs[0] = 4'h0; reqs[1] = 4'h1; reqs[2] = 4'h4;
    reqs[3] = 4'hB; reqs[4] = 4'h0;
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      state_req = reqs[$urandom_range(0, 4)];
      stall_ack = ($urandom_range(0, 5) == 0);
      ltssm_width = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) ltssm_up = !ltssm_up;
      if ($urandom_range(0, 9) == 0) ltssm_recovery = !ltssm_recovery;
      if ($urandom_range(0, 5) == 0) ltssm_l1 = !ltssm_l1;
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", c,
                 dut_vec(), model_vec());
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; state_req = 4'h0; stall_ack = 0; ltssm_up = 0;
    ltssm_recovery = 0; ltssm_l1 = 0; ltssm_width = 3'b000;
    model_clear(1);
    #1;
    test_reset();
    test_bringup();
    test_l1();
    test_recovery_priority();
    test_ll_retrain();
    test_timeout();
    test_drop_in_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
